// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one 32-bit instruction word per cycle into ALU controls,
// holds it toward execute, and stalls on RAW/WAW hazards against a register busy scoreboard.
module decode_issue #(
  parameter int unsigned NREG = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_iword,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opsel,
  output logic [3:0]  out_rs1,
  output logic [3:0]  out_rs2,
  output logic [3:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_reg_we,
  output logic        out_mem_re,
  output logic        out_mem_we,
  output logic        out_is_branch,
  output logic        out_is_jal,
  output logic        out_illegal,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd
);

  typedef enum logic [3:0] {
    OP_ALU_R  = 4'd0,
    OP_CMP_R  = 4'd2,
    OP_SW     = 4'd5,
    OP_BRANCH = 4'd6,
    OP_LW     = 4'd7,
    OP_ALU_I  = 4'd8,
    OP_CMP_I  = 4'd10,
    OP_JAL    = 4'd11
  } op_e;

  typedef struct packed {
    logic [5:0]  opsel;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        is_branch;
    logic        is_jal;
    logic        illegal;
  } dec_t;

  localparam logic [5:0] OPSEL_ADDR = 6'b100000;

  dec_t            dec;
  dec_t            held;
  logic            use_rs1;
  logic            use_rs2;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_set;
  logic [NREG-1:0] busy_clr;
  logic            held_we;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            rd_hit;
  logic            hazard;
  logic            accept;
  logic            issue;
  logic [3:0]      fn;

  assign fn = in_iword[27:24];

  always_comb begin
    dec         = '0;
    use_rs1     = 1'b1;
    use_rs2     = 1'b0;
    dec.rd      = in_iword[23:20];
    dec.rs1     = in_iword[19:16];
    dec.rs2     = in_iword[15:12];
    dec.imm     = {{16{in_iword[15]}}, in_iword[15:0]};
    case (op_e'(in_iword[31:28]))
      OP_ALU_R: begin
        dec.opsel  = {2'b00, fn};
        dec.reg_we = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_ALU_I: begin
        dec.opsel   = {2'b00, fn};
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
      end
      OP_CMP_R: begin
        dec.opsel  = {2'b01, fn};
        dec.reg_we = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_CMP_I: begin
        dec.opsel   = {2'b01, fn};
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
      end
      OP_BRANCH: begin
        dec.opsel     = {2'b01, fn};
        dec.is_branch = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_LW: begin
        dec.opsel   = OPSEL_ADDR;
        dec.use_imm = 1'b1;
        dec.mem_re  = 1'b1;
        dec.reg_we  = 1'b1;
      end
      OP_SW: begin
        dec.opsel   = OPSEL_ADDR;
        dec.use_imm = 1'b1;
        dec.mem_we  = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_JAL: begin
        dec.opsel   = OPSEL_ADDR;
        dec.use_imm = 1'b1;
        dec.is_jal  = 1'b1;
        dec.reg_we  = 1'b1;
      end
      default: begin
        // Illegal words use no sources and write nothing, so they never stall or mark busy.
        dec.illegal = 1'b1;
        use_rs1     = 1'b0;
      end
    endcase
  end

  always_comb begin
    held_we = out_valid && held.reg_we;
    rs1_hit = use_rs1 && (busy[dec.rs1] || (held_we && held.rd == dec.rs1));
    rs2_hit = use_rs2 && (busy[dec.rs2] || (held_we && held.rd == dec.rs2));
    rd_hit  = dec.reg_we && (busy[dec.rd] || (held_we && held.rd == dec.rd));
    hazard  = rs1_hit || rs2_hit || rd_hit;
  end

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // A flushed instruction is discarded, so it must not mark its destination busy.
  assign issue    = out_valid && out_ready && held.reg_we && !flush;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue) begin
      busy_set[held.rd] = 1'b1;
    end
    if (wb_valid) begin
      busy_clr[wb_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_opsel     = held.opsel;
  assign out_rs1       = held.rs1;
  assign out_rs2       = held.rs2;
  assign out_rd        = held.rd;
  assign out_imm       = held.imm;
  assign out_use_imm   = held.use_imm;
  assign out_reg_we    = held.reg_we;
  assign out_mem_re    = held.mem_re;
  assign out_mem_we    = held.mem_we;
  assign out_is_branch = held.is_branch;
  assign out_is_jal    = held.is_jal;
  assign out_illegal   = held.illegal;

endmodule

// File: doc/decode_issue.md
# decode_issue

Instruction decode and issue stage that produces the 6-bit `opsel` word and operand controls consumed by the ALU. Accepts 32-bit instruction words from fetch over a valid/ready handshake and registers one decoded instruction toward execute. Tracks outstanding register writes in a 16-entry busy scoreboard and stalls on RAW/WAW hazards. Supports a single-cycle flush for taken branches.

## Interface

- `NREG`, 16, architectural register count; scoreboard width.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `flush`  in  1  discard the held instruction and the current input.
- `in_valid`  in  1  `in_iword` is valid.
- `in_iword`  in  32  instruction word.
- `in_ready`  out  1  the stage accepts `in_iword` this cycle.
- `out_valid`  out  1  decoded instruction is held.
- `out_ready`  in  1  execute accepts the held instruction.
- `out_opsel`  out  6  ALU op select.
- `out_rs1`, `out_rs2`, `out_rd`  out  4 each  register indices.
- `out_imm`  out  32  sign-extended `iword[15:0]`.
- `out_use_imm`  out  1  ALU B operand = `out_imm`.
- `out_reg_we`, `out_mem_re`, `out_mem_we`, `out_is_branch`, `out_is_jal`, `out_illegal`  out  1 each  control flags.
- `wb_valid`  in  1  a register write completes.
- `wb_rd`  in  4  register written back.

## Operation

- Fields: `op=iword[31:28]`, `fn=iword[27:24]`, `rd=iword[23:20]`, `rs1=iword[19:16]`, `rs2=iword[15:12]`, `imm=iword[15:0]`.
- opsel classes: `{2'b00,fn}` arithmetic/logic, `{2'b01,fn}` compare, `6'b100000` address (A + B*4).
- op 0 ALU-R: rd=rs1 fn rs2; reg_we=1.
- op 8 ALU-I: use_imm=1; reg_we=1.
- op 2 CMP-R / op 10 CMP-I: compare class; reg_we=1; CMP-I sets use_imm.
- op 6 BRANCH: compare class on rs1, rs2; is_branch=1; no write.
- op 7 LW: address class, use_imm, mem_re=1, reg_we=1.
- op 5 SW: address class, use_imm, mem_we=1; rs2 = store data.
- op 11 JAL: address class, use_imm, is_jal=1, reg_we=1.
- Any other op: illegal=1; all write/memory flags 0; the instruction passes through and never touches the scoreboard.
- Source usage: rs1 for all legal ops; rs2 for ALU-R, CMP-R, BRANCH, SW.
- Hazard: a used source, or rd when reg_we, matches a set busy bit, or matches `out_rd` of a held instruction with `out_reg_we`.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- Scoreboard: set `busy[out_rd]` when `out_valid && out_ready && out_reg_we`; clear `busy[wb_rd]` on `wb_valid`. Set and clear of the same index in one cycle: set wins.
- Flush: `out_valid` clears next edge; input is not accepted; the scoreboard is unchanged (a set requires a handshake).

## Timing

- Reset: `out_valid=0`, every `out_*` = 0, `busy=0`, `in_ready` follows its equation (1 when there is no flush).
- Latency: 1 cycle from an accepted input to `out_valid`/fields.
- Held fields stay stable while `out_valid && !out_ready`.
- Back-to-back: with `out_ready=1` and no hazard, throughput is 1 instruction/cycle.
- Hazard check reads registered `busy`. A same-cycle `wb_valid` does not release a stall until the next cycle. No bypass.
- Reset mid-stall or mid-flush returns the stage to the reset state immediately.

## Test plan

- Reset: assert `reset`, then deassert -> `out_valid=0`, `busy=0`, `in_ready=1`.
- Issue ADD r3=r1+r2 (`0x00312000`), `out_ready=1` -> next cycle `opsel=6'h00`, rd=3, reg_we=1. After the handshake, `busy[3]=1`.
- Immediately follow with ALU-I using rs1=3 (`0x80430005`) -> `in_ready=0` until the cycle after `wb_valid`, `wb_rd=3`. Then it issues with `imm=32'h5`, `use_imm=1`.
- LW r4,[r1+-1] (`0x7041FFFF`) -> `opsel=6'h20`, `imm=32'hFFFFFFFF`, mem_re=1, reg_we=1.
- Hold `out_ready=0` with BRANCH EQ (`0x61012000`) held, then pulse `flush` -> `out_valid=0` next cycle, no busy bit set, the input is not accepted.
- Illegal op `0xF0000000` -> `illegal=1`, all flags 0. A later instruction whose rd equals the illegal instruction's rd issues without stall.
